// File: rtl/reg4_write_arbiter.sv
// reg4_write_arbiter
// Round-robin arbiter that lets NREQ producers take turns writing one shared
// WIDTH-bit register. A granted write commits with a one-cycle ack, then a
// cool-down of COOL_CYCLES idle cycles keeps the visible value stable.

module reg4_write_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int COOL_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        q,
    output logic [2:0]              owner,
    output logic                    busy,
    output logic [CNT_W-1:0]        write_count
);

    // Cool-down counter must hold COOL_CYCLES; keep at least one bit.
    localparam int COOL_W = (COOL_CYCLES < 1) ? 1 : $clog2(COOL_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_grant;
    logic [2:0]           r_ptr;
    logic [WIDTH-1:0]     r_q;
    logic [NREQ-1:0]      r_ack;
    logic [2:0]           r_owner;
    logic [CNT_W-1:0]     r_count;
    logic [COOL_W-1:0]    r_cool;

    state_t               w_state_nxt;
    logic [2:0]           w_grant_nxt;
    logic [2:0]           w_ptr_nxt;
    logic [WIDTH-1:0]     w_q_nxt;
    logic [NREQ-1:0]      w_ack_nxt;
    logic [2:0]           w_owner_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [COOL_W-1:0]    w_cool_nxt;

    logic [2*NREQ-1:0]    w_req_dbl;
    logic [NREQ-1:0]      w_rot;
    logic                 w_found;
    logic [2:0]           w_sel;
    logic                 w_req_g;
    logic [WIDTH-1:0]     w_wdata_g;
    logic [NREQ-1:0]      w_ack_g;

    // Rotate requests so bit 0 corresponds to the current priority pointer.
    always_comb begin
        w_req_dbl = {req, req};
        w_rot     = NREQ'(w_req_dbl >> r_ptr);
    end

    // Pick the first active requester at or after the pointer, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sel   = ((int'(r_ptr) + k) >= NREQ) ? 3'(int'(r_ptr) + k - NREQ)
                                                      : 3'(int'(r_ptr) + k);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Decode the latched grant into its request bit, data slice and ack mask.
    always_comb begin
        w_req_g   = 1'b0;
        w_wdata_g = '0;
        w_ack_g   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant == 3'(i)) begin
                w_req_g    = req[i];
                w_wdata_g  = wdata[i*WIDTH +: WIDTH];
                w_ack_g[i] = 1'b1;
            end else begin
                w_ack_g[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic of the IDLE/WRITE/COOL controller.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_q_nxt     = r_q;
        w_ack_nxt   = '0;
        w_owner_nxt = r_owner;
        w_count_nxt = r_count;
        w_cool_nxt  = r_cool;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_WRITE;
                    w_grant_nxt = w_sel;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (w_req_g) begin
                    w_q_nxt     = w_wdata_g;
                    w_ack_nxt   = w_ack_g;
                    w_owner_nxt = r_grant;
                    w_ptr_nxt   = (r_grant == 3'(NREQ - 1)) ? 3'd0 : r_grant + 3'd1;
                    w_count_nxt = r_count + CNT_W'(1);
                    if (COOL_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_COOL;
                        w_cool_nxt  = COOL_W'(COOL_CYCLES);
                    end
                end else begin
                    // Requester withdrew before commit: abandon silently.
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COOL: begin
                // COOL lasts exactly COOL_CYCLES cycles; leave as the count hits zero.
                if (r_cool <= COOL_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cool_nxt  = '0;
                end else begin
                    w_cool_nxt  = r_cool - COOL_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cool_nxt  = '0;
            end
        endcase
    end

    // State and output registers; reset overrides any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= 3'd0;
            r_ptr   <= 3'd0;
            r_q     <= '0;
            r_ack   <= '0;
            r_owner <= 3'd0;
            r_count <= '0;
            r_cool  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_q     <= w_q_nxt;
            r_ack   <= w_ack_nxt;
            r_owner <= w_owner_nxt;
            r_count <= w_count_nxt;
            r_cool  <= w_cool_nxt;
        end
    end

    assign ack         = r_ack;
    assign q           = r_q;
    assign owner       = r_owner;
    assign write_count = r_count;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Directed bench for reg4_write_arbiter with default parameters.

module tb_reg4_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  ack;
    logic [3:0]  q;
    logic [2:0]  owner;
    logic        busy;
    logic [7:0]  write_count;

    int n_assert;
    int n_fail;

    reg4_write_arbiter #(
        .NREQ        (4),
        .WIDTH       (4),
        .COOL_CYCLES (2),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .wdata       (wdata),
        .ack         (ack),
        .q           (q),
        .owner       (owner),
        .busy        (busy),
        .write_count (write_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        int cyc;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req      = 4'b0000;
        wdata    = 16'h0000;

        // 1. Reset with all requests high.
        req   = 4'b1111;
        wdata = 16'h4321;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_q", 32'(q), 32'h0);
            chk("rst_ack", 32'(ack), 32'h0);
            chk("rst_owner", 32'(owner), 32'h0);
            chk("rst_cnt", 32'(write_count), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        reset = 1'b0;
        tick();
        chk("rst_busy_grant", 32'(busy), 32'h1);
        tick();
        chk("rst_first_ack", 32'(ack), 32'h1);
        chk("rst_first_q", 32'(q), 32'h1);
        req = 4'b0000;

        // 2. Single write from requester 2.
        do_reset();
        req   = 4'b0100;
        wdata = 16'h0A00;
        tick();
        chk("s2_ack_early", 32'(ack), 32'h0);
        chk("s2_busy_w", 32'(busy), 32'h1);
        tick();
        chk("s2_ack", 32'(ack), 32'h4);
        chk("s2_q", 32'(q), 32'hA);
        chk("s2_owner", 32'(owner), 32'h2);
        chk("s2_cnt", 32'(write_count), 32'h1);
        chk("s2_busy_c1", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("s2_ack_pulse", 32'(ack), 32'h0);
        chk("s2_busy_c2", 32'(busy), 32'h1);
        tick();
        chk("s2_busy_idle", 32'(busy), 32'h0);
        chk("s2_q_hold", 32'(q), 32'hA);

        // 3. Round-robin with all four requesting continuously.
        do_reset();
        req   = 4'b1111;
        wdata = 16'h4321;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s3_ack", 32'(ack), 32'(1 << (i % 4)));
            chk("s3_q", 32'(q), 32'((i % 4) + 1));
            chk("s3_owner", 32'(owner), 32'(i % 4));
            if (i < 4) begin
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk("s3_gap_ack", 32'(ack), 32'h0);
                end
            end
        end
        chk("s3_cnt", 32'(write_count), 32'h5);
        req = 4'b0000;
        tick();
        tick();
        tick();

        // 4. Abort: requester 1 drops in the WRITE cycle.
        do_reset();
        req   = 4'b0010;
        wdata = 16'h0070;
        tick();
        chk("s4_busy_w", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("s4_ack", 32'(ack), 32'h0);
        chk("s4_busy", 32'(busy), 32'h0);
        chk("s4_q", 32'(q), 32'h0);
        chk("s4_cnt", 32'(write_count), 32'h0);
        req   = 4'b1000;
        wdata = 16'h9070;
        tick();
        chk("s4_ack2_early", 32'(ack), 32'h0);
        tick();
        chk("s4_ack2", 32'(ack), 32'h8);
        chk("s4_q2", 32'(q), 32'h9);
        chk("s4_owner2", 32'(owner), 32'h3);
        chk("s4_cnt2", 32'(write_count), 32'h1);
        req = 4'b0000;

        // 5. Reset arriving during the WRITE cycle.
        do_reset();
        req   = 4'b0001;
        wdata = 16'h0005;
        tick();
        chk("s5_busy_w", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b0000;
        chk("s5_ack", 32'(ack), 32'h0);
        chk("s5_q", 32'(q), 32'h0);
        chk("s5_busy", 32'(busy), 32'h0);
        tick();
        chk("s5_ack_after", 32'(ack), 32'h0);
        chk("s5_q_after", 32'(q), 32'h0);
        chk("s5_cnt", 32'(write_count), 32'h0);

        // 6. 256 writes from requester 1, data alternating 3/C.
        do_reset();
        req   = 4'b0010;
        wdata = 16'h0030;
        for (int n = 1; n <= 256; n++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (ack === 4'b0000 && cyc < 8);
            chk("s6_ack", 32'(ack), 32'h2);
            chk("s6_spacing", 32'(cyc), (n == 1) ? 32'd2 : 32'd4);
            chk("s6_q", 32'(q), (n % 2 == 1) ? 32'h3 : 32'hC);
            if (n == 255) begin
                chk("s6_cnt_ff", 32'(write_count), 32'hFF);
            end
            wdata = (n % 2 == 1) ? 16'h00C0 : 16'h0030;
        end
        req = 4'b0000;
        chk("s6_cnt_wrap", 32'(write_count), 32'h0);
        chk("s6_owner", 32'(owner), 32'h1);
        chk("s6_q_final", 32'(q), 32'hC);
        tick();
        chk("s6_ack_end", 32'(ack), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
